// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: picks the winning exception, interrupt or
// MRET at commit, builds the CSR update values and the redirect target, then
// walks the pipeline through write -> flush/redirect -> resume.
module trap_ctrl #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter bit          VECTORED_EN = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        valid_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] next_pc_i,
  input  logic        exc_fetch_mis_i,
  input  logic        exc_illegal_i,
  input  logic        exc_ebreak_i,
  input  logic        exc_ecall_i,
  input  logic        exc_load_mis_i,
  input  logic        exc_store_mis_i,
  input  logic [31:0] bad_addr_i,
  input  logic [31:0] instr_i,
  input  logic        mret_i,
  input  logic        irq_ext_i,
  input  logic        irq_sw_i,
  input  logic        irq_timer_i,
  input  logic [31:0] mie_i,
  input  logic [31:0] mstatus_i,
  input  logic [31:0] mtvec_i,
  input  logic [31:0] mepc_i,
  output logic        we_exc_o,
  output logic [31:0] mcause_o,
  output logic [31:0] mepc_o,
  output logic [31:0] mtval_o,
  output logic [31:0] mstatus_o,
  output logic        stall_o,
  output logic        flush_o,
  output logic        redirect_o,
  output logic [31:0] trap_pc_o
);

  typedef enum logic [1:0] {S_IDLE, S_TRAP, S_MRET, S_JUMP} state_e;

  state_e      state_q, state_d;
  logic [31:0] mcause_q, mcause_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] mtval_q, mtval_d;
  logic [31:0] mstatus_q, mstatus_d;
  logic [31:0] trap_pc_q, trap_pc_d;

  logic        exc_any, irq_any, ext_en, sw_en, tmr_en;
  logic        take_exc, take_mret, take_irq;
  logic [30:0] exc_code, irq_code;
  logic [31:0] exc_tval, base;
  logic        unused_bits;

  // Only mie bits 11/7/3 and the word-aligned part of mepc matter here.
  assign unused_bits = ^{mepc_i[1:0], mie_i};

  // Event decode and prioritisation; only acted on when IDLE.
  always_comb begin
    exc_any  = exc_fetch_mis_i | exc_illegal_i | exc_ebreak_i |
               exc_ecall_i | exc_load_mis_i | exc_store_mis_i;
    ext_en   = irq_ext_i   & mie_i[11];
    sw_en    = irq_sw_i    & mie_i[3];
    tmr_en   = irq_timer_i & mie_i[7];
    irq_any  = mstatus_i[3] & (ext_en | sw_en | tmr_en);

    exc_code = 31'd6;
    exc_tval = bad_addr_i;
    if (exc_fetch_mis_i) begin
      exc_code = 31'd0;  exc_tval = bad_addr_i;
    end else if (exc_illegal_i) begin
      exc_code = 31'd2;  exc_tval = instr_i;
    end else if (exc_ebreak_i) begin
      exc_code = 31'd3;  exc_tval = 32'h0;
    end else if (exc_ecall_i) begin
      exc_code = 31'd11; exc_tval = 32'h0;
    end else if (exc_load_mis_i) begin
      exc_code = 31'd4;  exc_tval = bad_addr_i;
    end

    if (ext_en)     irq_code = 31'd11;
    else if (sw_en) irq_code = 31'd3;
    else            irq_code = 31'd7;

    take_exc  = (state_q == S_IDLE) && valid_i && exc_any;
    take_mret = (state_q == S_IDLE) && valid_i && !exc_any && mret_i;
    take_irq  = (state_q == S_IDLE) && valid_i && !exc_any && !mret_i && irq_any;

    base = {mtvec_i[31:2], 2'b00};
  end

  // CSR update values and redirect target, captured on the event cycle.
  always_comb begin
    mcause_d  = mcause_q;
    mepc_d    = mepc_q;
    mtval_d   = mtval_q;
    mstatus_d = mstatus_q;
    trap_pc_d = trap_pc_q;
    if (take_exc || take_irq) begin
      mcause_d  = take_exc ? {1'b0, exc_code} : {1'b1, irq_code};
      mepc_d    = take_exc ? pc_i : next_pc_i;
      mtval_d   = take_exc ? exc_tval : 32'h0;
      mstatus_d = mstatus_i;
      mstatus_d[7]     = mstatus_i[3];
      mstatus_d[3]     = 1'b0;
      mstatus_d[12:11] = 2'b11;
      if (VECTORED_EN && take_irq && (mtvec_i[1:0] == 2'b01))
        trap_pc_d = base + {irq_code[29:0], 2'b00};
      else
        trap_pc_d = base;
    end else if (take_mret) begin
      mstatus_d = mstatus_i;
      mstatus_d[3]     = mstatus_i[7];
      mstatus_d[7]     = 1'b1;
      mstatus_d[12:11] = 2'b11;
      trap_pc_d = {mepc_i[31:2], 2'b00};
    end
  end

  // Next-state: event -> write cycle -> redirect cycle -> idle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (take_exc || take_irq) state_d = S_TRAP;
              else if (take_mret)       state_d = S_MRET;
      S_TRAP,
      S_MRET: state_d = S_JUMP;
      S_JUMP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and captured values; reset drops any sequence in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      mcause_q  <= 32'h0;
      mepc_q    <= 32'h0;
      mtval_q   <= 32'h0;
      mstatus_q <= 32'h0;
      trap_pc_q <= RESET_PC;
    end else begin
      state_q   <= state_d;
      mcause_q  <= mcause_d;
      mepc_q    <= mepc_d;
      mtval_q   <= mtval_d;
      mstatus_q <= mstatus_d;
      trap_pc_q <= trap_pc_d;
    end
  end

  // Pipeline controls decoded from the current state.
  always_comb begin
    we_exc_o   = (state_q == S_TRAP) || (state_q == S_MRET);
    stall_o    = (state_q != S_IDLE);
    flush_o    = (state_q == S_JUMP);
    redirect_o = (state_q == S_JUMP);
  end

  assign mcause_o  = mcause_q;
  assign mepc_o    = mepc_q;
  assign mtval_o   = mtval_q;
  assign mstatus_o = mstatus_q;
  assign trap_pc_o = trap_pc_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed vector bench for trap_ctrl: table of single events plus a few
// hand-written multi-cycle sequences (reset mid-trap, event during trap).
module tb_trap_ctrl;
  localparam logic [31:0] RST_PC = 32'h0000_1000;

  logic        clk, rst_n, valid, mret, ext, sw, tmr;
  logic [5:0]  exc; // {store, load, ecall, ebreak, illegal, fetch}
  logic [31:0] pc, npc, bad, instr, mie, mst, mtvec, mepc;
  logic        we, stall, flush, redir;
  logic [31:0] o_mcause, o_mepc, o_mtval, o_mst, o_pc;

  int n_cmp = 0;
  int n_err = 0;

  trap_ctrl #(.RESET_PC(RST_PC), .VECTORED_EN(1'b1)) dut (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid), .pc_i(pc), .next_pc_i(npc),
    .exc_fetch_mis_i(exc[0]), .exc_illegal_i(exc[1]), .exc_ebreak_i(exc[2]),
    .exc_ecall_i(exc[3]), .exc_load_mis_i(exc[4]), .exc_store_mis_i(exc[5]),
    .bad_addr_i(bad), .instr_i(instr), .mret_i(mret),
    .irq_ext_i(ext), .irq_sw_i(sw), .irq_timer_i(tmr),
    .mie_i(mie), .mstatus_i(mst), .mtvec_i(mtvec), .mepc_i(mepc),
    .we_exc_o(we), .mcause_o(o_mcause), .mepc_o(o_mepc), .mtval_o(o_mtval),
    .mstatus_o(o_mst), .stall_o(stall), .flush_o(flush), .redirect_o(redir),
    .trap_pc_o(o_pc));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] name;
    logic        valid;
    logic [5:0]  exc;
    logic        mret;
    logic [2:0]  irq; // {ext, sw, timer}
    logic [31:0] pc, npc, bad, instr, mie, mst, mtvec, mepc;
    logic        trap;
    logic [31:0] e_mcause, e_mepc, e_mtval, e_mst, e_pc;
  } vec_t;

  function automatic vec_t mk(logic [63:0] name, logic v, logic [5:0] e,
      logic m, logic [2:0] i, logic [31:0] p, logic [31:0] np, logic [31:0] b,
      logic [31:0] ins, logic [31:0] ie, logic [31:0] st, logic [31:0] tv,
      logic [31:0] ep, logic t, logic [31:0] c, logic [31:0] xp,
      logic [31:0] tval, logic [31:0] xst, logic [31:0] tpc);
    vec_t r;
    r.name = name; r.valid = v; r.exc = e; r.mret = m; r.irq = i;
    r.pc = p; r.npc = np; r.bad = b; r.instr = ins; r.mie = ie; r.mst = st;
    r.mtvec = tv; r.mepc = ep; r.trap = t; r.e_mcause = c; r.e_mepc = xp;
    r.e_mtval = tval; r.e_mst = xst; r.e_pc = tpc;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic clear_in();
    valid = 0; exc = 0; mret = 0; ext = 0; sw = 0; tmr = 0;
    pc = 0; npc = 0; bad = 0; instr = 0; mie = 0; mst = 0; mtvec = 0; mepc = 0;
  endtask

  task automatic apply(input vec_t v);
    valid = v.valid; exc = v.exc; mret = v.mret;
    {ext, sw, tmr} = v.irq;
    pc = v.pc; npc = v.npc; bad = v.bad; instr = v.instr;
    mie = v.mie; mst = v.mst; mtvec = v.mtvec; mepc = v.mepc;
  endtask

  vec_t vecs[14];
  logic [31:0] l_mcause, l_mepc, l_mtval, l_mst, l_pc;

  initial begin
    //               name        v  exc        m  irq     pc     npc    bad    instr         mie    mst     mtvec  mepc   trap mcause        mepc   mtval         mstatus  trap_pc
    vecs[0]  = mk("ecall",    1, 6'b001000, 0, 3'b000, 32'h80, 32'h84, 32'h0, 32'h0,        32'h0,   32'h0,    32'h101, 32'h0,    1, 32'h0000_000B, 32'h80, 32'h0,        32'h1800, 32'h100);
    vecs[1]  = mk("ill_ld",   1, 6'b010010, 0, 3'b000, 32'h200,32'h204,32'h1234,32'hFFFF_FFFF,32'h0, 32'h8,    32'h101, 32'h0,    1, 32'h0000_0002, 32'h200,32'hFFFF_FFFF,32'h1880, 32'h100);
    vecs[2]  = mk("timer",    1, 6'b000000, 0, 3'b001, 32'h40, 32'h44, 32'h0, 32'h0,        32'h80,  32'h8,    32'h201, 32'h0,    1, 32'h8000_0007, 32'h44, 32'h0,        32'h1880, 32'h21C);
    vecs[3]  = mk("tmr_off",  1, 6'b000000, 0, 3'b001, 32'h40, 32'h44, 32'h0, 32'h0,        32'h80,  32'h0,    32'h201, 32'h0,    0, 32'h0,         32'h0,  32'h0,        32'h0,    32'h0);
    vecs[4]  = mk("irq_all",  1, 6'b000000, 0, 3'b111, 32'h44, 32'h48, 32'h0, 32'h0,        32'h888, 32'h8,    32'h201, 32'h0,    1, 32'h8000_000B, 32'h48, 32'h0,        32'h1880, 32'h22C);
    vecs[5]  = mk("irq_ebrk", 1, 6'b000100, 0, 3'b111, 32'h44, 32'h48, 32'h0, 32'h0,        32'h888, 32'h8,    32'h201, 32'h0,    1, 32'h0000_0003, 32'h44, 32'h0,        32'h1880, 32'h200);
    vecs[6]  = mk("mret",     1, 6'b000000, 1, 3'b001, 32'h90, 32'h94, 32'h0, 32'h0,        32'h80,  32'h1880, 32'h201, 32'h1237, 1, 32'h0000_0003, 32'h44, 32'h0,        32'h1888, 32'h1234);
    vecs[7]  = mk("fetch",    1, 6'b000001, 0, 3'b000, 32'h10, 32'h14, 32'h3, 32'h0,        32'h0,   32'h0,    32'h0,   32'h0,    1, 32'h0000_0000, 32'h10, 32'h3,        32'h1800, 32'h0);
    vecs[8]  = mk("store",    1, 6'b100000, 0, 3'b000, 32'h14, 32'h18, 32'h55, 32'h0,       32'h0,   32'h1800, 32'h8,   32'h0,    1, 32'h0000_0006, 32'h14, 32'h55,       32'h1800, 32'h8);
    vecs[9]  = mk("novalid",  0, 6'b001000, 0, 3'b000, 32'h20, 32'h24, 32'h0, 32'h0,        32'h0,   32'h0,    32'h101, 32'h0,    0, 32'h0,         32'h0,  32'h0,        32'h0,    32'h0);
    vecs[10] = mk("sw_irq",   1, 6'b000000, 0, 3'b010, 32'h5C, 32'h60, 32'h0, 32'h0,        32'h8,   32'h8,    32'h301, 32'h0,    1, 32'h8000_0003, 32'h60, 32'h0,        32'h1880, 32'h30C);
    vecs[11] = mk("ext_mie0", 1, 6'b000000, 0, 3'b100, 32'h5C, 32'h60, 32'h0, 32'h0,        32'h0,   32'h8,    32'h201, 32'h0,    0, 32'h0,         32'h0,  32'h0,        32'h0,    32'h0);
    vecs[12] = mk("ec_ld_st", 1, 6'b111000, 0, 3'b000, 32'h70, 32'h74, 32'h99, 32'h0,       32'h0,   32'h80,   32'h101, 32'h0,    1, 32'h0000_000B, 32'h70, 32'h0,        32'h1800, 32'h100);
    vecs[13] = mk("ld_st",    1, 6'b110000, 0, 3'b000, 32'h78, 32'h7C, 32'h99, 32'h0,       32'h0,   32'h0,    32'h101, 32'h0,    1, 32'h0000_0004, 32'h78, 32'h99,       32'h1800, 32'h100);

    clear_in();
    rst_n = 0;
    repeat (2) @(negedge clk);
    chk("rst_we", {31'b0, we}, 32'h0);
    chk("rst_stall", {31'b0, stall}, 32'h0);
    chk("rst_flush", {31'b0, flush}, 32'h0);
    chk("rst_redir", {31'b0, redir}, 32'h0);
    chk("rst_mcause", o_mcause, 32'h0);
    chk("rst_mstatus", o_mst, 32'h0);
    chk("rst_trap_pc", o_pc, RST_PC);
    rst_n = 1;
    @(negedge clk);
    l_mcause = 0; l_mepc = 0; l_mtval = 0; l_mst = 0; l_pc = RST_PC;

    for (int i = 0; i < 14; i++) begin
      apply(vecs[i]);
      @(negedge clk);
      clear_in();
      if (vecs[i].trap) begin
        chk($sformatf("%0s_we", vecs[i].name), {31'b0, we}, 32'h1);
        chk($sformatf("%0s_stall1", vecs[i].name), {31'b0, stall}, 32'h1);
        chk($sformatf("%0s_redir1", vecs[i].name), {31'b0, redir}, 32'h0);
        chk($sformatf("%0s_mcause", vecs[i].name), o_mcause, vecs[i].e_mcause);
        chk($sformatf("%0s_mepc", vecs[i].name), o_mepc, vecs[i].e_mepc);
        chk($sformatf("%0s_mtval", vecs[i].name), o_mtval, vecs[i].e_mtval);
        chk($sformatf("%0s_mstatus", vecs[i].name), o_mst, vecs[i].e_mst);
        @(negedge clk);
        chk($sformatf("%0s_we_once", vecs[i].name), {31'b0, we}, 32'h0);
        chk($sformatf("%0s_redir", vecs[i].name), {31'b0, redir}, 32'h1);
        chk($sformatf("%0s_flush", vecs[i].name), {31'b0, flush}, 32'h1);
        chk($sformatf("%0s_stall2", vecs[i].name), {31'b0, stall}, 32'h1);
        chk($sformatf("%0s_trap_pc", vecs[i].name), o_pc, vecs[i].e_pc);
        @(negedge clk);
        chk($sformatf("%0s_idle_stall", vecs[i].name), {31'b0, stall}, 32'h0);
        chk($sformatf("%0s_idle_redir", vecs[i].name), {31'b0, redir}, 32'h0);
        chk($sformatf("%0s_pc_hold", vecs[i].name), o_pc, vecs[i].e_pc);
        l_mcause = vecs[i].e_mcause; l_mepc = vecs[i].e_mepc;
        l_mtval = vecs[i].e_mtval; l_mst = vecs[i].e_mst; l_pc = vecs[i].e_pc;
      end else begin
        chk($sformatf("%0s_no_we", vecs[i].name), {31'b0, we}, 32'h0);
        chk($sformatf("%0s_no_stall", vecs[i].name), {31'b0, stall}, 32'h0);
        chk($sformatf("%0s_mcause_hold", vecs[i].name), o_mcause, l_mcause);
        chk($sformatf("%0s_mstatus_hold", vecs[i].name), o_mst, l_mst);
        chk($sformatf("%0s_pc_hold", vecs[i].name), o_pc, l_pc);
        @(negedge clk);
        chk($sformatf("%0s_no_redir", vecs[i].name), {31'b0, redir}, 32'h0);
      end
    end

    // A new event while in TRAP must be ignored.
    apply(vecs[0]);
    @(negedge clk);
    chk("busy_we", {31'b0, we}, 32'h1);
    apply(vecs[1]);
    @(negedge clk);
    chk("busy_redir", {31'b0, redir}, 32'h1);
    chk("busy_we_low", {31'b0, we}, 32'h0);
    chk("busy_mcause", o_mcause, 32'h0000_000B);
    chk("busy_mtval", o_mtval, 32'h0);
    clear_in();
    @(negedge clk);
    chk("busy_idle", {31'b0, stall}, 32'h0);
    chk("busy_pc_hold", o_pc, 32'h100);

    // Reset in the middle of a trap aborts everything.
    apply(vecs[0]);
    @(negedge clk);
    chk("midrst_we_pre", {31'b0, we}, 32'h1);
    rst_n = 0;
    #1;
    chk("midrst_we", {31'b0, we}, 32'h0);
    chk("midrst_stall", {31'b0, stall}, 32'h0);
    chk("midrst_mcause", o_mcause, 32'h0);
    chk("midrst_mepc", o_mepc, 32'h0);
    chk("midrst_mtval", o_mtval, 32'h0);
    chk("midrst_mstatus", o_mst, 32'h0);
    chk("midrst_trap_pc", o_pc, RST_PC);
    clear_in();
    @(negedge clk);
    chk("midrst_redir", {31'b0, redir}, 32'h0);
    chk("midrst_flush", {31'b0, flush}, 32'h0);
    rst_n = 1;
    @(negedge clk);
    chk("midrst_idle", {31'b0, stall}, 32'h0);
    chk("midrst_no_we", {31'b0, we}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
